// File: rtl/m_uart_tx_arb.sv
// ---------------------------------------------------------------------------
// m_uart_tx_arb
//
// Purpose:
//   Shares one UART transmit line between two byte sources. A round-robin
//   arbiter picks a requester, latches its byte, and then sequences a full
//   serial frame (sync period, start bit, data bits LSB first, stop bits).
//   Bit timing comes from an external baud-tick generator: this block raises
//   o_bps_en for the duration of a frame and advances one bit per
//   i_bps_done pulse.
//
// Parameters:
//   DATA_BITS  data bits per frame, LSB first (5..8)
//   STOP_BITS  stop bits per frame (1 or 2)
//
// Ports:
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_req0       requester 0 send request, held with i_data0 until o_ack0
//   i_data0      requester 0 byte
//   o_ack0       one-cycle pulse, requester 0 byte latched
//   i_req1       requester 1 send request, held with i_data1 until o_ack1
//   i_data1      requester 1 byte
//   o_ack1       one-cycle pulse, requester 1 byte latched
//   o_bps_en     enable for the baud generator (its counter clears while low)
//   i_bps_done   one-cycle pulse per bit period while o_bps_en is high
//   o_uart_tx    serial line, idle high
//   o_busy       high whenever a frame is in progress
//   o_grant_id   id of the requester owning the current or last frame
//   o_done       one-cycle pulse at the end of the final stop bit
// ---------------------------------------------------------------------------
module m_uart_tx_arb #(
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_req0,
   input  logic [DATA_BITS-1:0] i_data0,
   output logic                 o_ack0,
   input  logic                 i_req1,
   input  logic [DATA_BITS-1:0] i_data1,
   output logic                 o_ack1,
   output logic                 o_bps_en,
   input  logic                 i_bps_done,
   output logic                 o_uart_tx,
   output logic                 o_busy,
   output logic                 o_grant_id,
   output logic                 o_done
);

   // Frame sequencer states. SYNC burns one whole baud period after the
   // grant so that the start bit begins on a clean period boundary of the
   // freshly enabled baud generator.
   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      START,
      DATA,
      STOP
   } txState_t;

   // Terminal counts for the bit and stop counters, sized to the counters
   // themselves so the comparisons below are width-exact.
   localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
   localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

   txState_t             state;
   logic [DATA_BITS-1:0] shiftReg;
   logic [2:0]           bitCnt;
   logic                 stopCnt;
   logic                 favourId;
   logic                 anyReq;
   logic                 winner;

   // Arbitration decision for the current cycle. favourId names the
   // requester that did not win the previous grant, so when both requesters
   // are asking the one that waited last time goes first. A lone requester
   // always wins regardless of whose turn it would be.
   always_comb begin
      anyReq = i_req0 | i_req1;
      winner = 1'b0;
      if (i_req0 && i_req1) begin
         winner = favourId;
      end else if (i_req1) begin
         winner = 1'b1;
      end
   end

   // Single sequencer register block. Every output is a register written
   // here; ack and done default low each cycle so they only ever pulse for
   // one clock. The shift register is loaded only on a grant, which makes
   // the transmitted byte immune to later changes on the data inputs.
   // Data goes out LSB first: each bit period drives bit 0 of the shift
   // register onto the line and shifts right, so the next bit is already
   // in position for the following baud tick. A reset at any point drops
   // the frame and returns the line to idle high with the generator off.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         shiftReg   <= '0;
         bitCnt     <= '0;
         stopCnt    <= 1'b0;
         favourId   <= 1'b0;
         o_ack0     <= 1'b0;
         o_ack1     <= 1'b0;
         o_bps_en   <= 1'b0;
         o_uart_tx  <= 1'b1;
         o_busy     <= 1'b0;
         o_grant_id <= 1'b0;
         o_done     <= 1'b0;
      end else begin
         o_ack0 <= 1'b0;
         o_ack1 <= 1'b0;
         o_done <= 1'b0;

         case (state)
            IDLE: begin
               if (anyReq) begin
                  state      <= SYNC;
                  o_ack0     <= ~winner;
                  o_ack1     <= winner;
                  o_bps_en   <= 1'b1;
                  o_busy     <= 1'b1;
                  o_grant_id <= winner;
                  favourId   <= ~winner;
                  shiftReg   <= winner ? i_data1 : i_data0;
                  o_uart_tx  <= 1'b1;
               end
            end

            SYNC: begin
               if (i_bps_done) begin
                  o_uart_tx <= 1'b0;
                  state     <= START;
               end
            end

            START: begin
               if (i_bps_done) begin
                  o_uart_tx <= shiftReg[0];
                  shiftReg  <= shiftReg >> 1;
                  bitCnt    <= 3'd0;
                  state     <= DATA;
               end
            end

            DATA: begin
               if (i_bps_done) begin
                  if (bitCnt != LAST_BIT) begin
                     o_uart_tx <= shiftReg[0];
                     shiftReg  <= shiftReg >> 1;
                     bitCnt    <= bitCnt + 3'd1;
                  end else begin
                     o_uart_tx <= 1'b1;
                     stopCnt   <= 1'b0;
                     state     <= STOP;
                  end
               end
            end

            STOP: begin
               if (i_bps_done) begin
                  if (stopCnt != LAST_STOP) begin
                     stopCnt <= stopCnt + 1'b1;
                  end else begin
                     state    <= IDLE;
                     o_bps_en <= 1'b0;
                     o_busy   <= 1'b0;
                     o_done   <= 1'b1;
                  end
               end
            end

            default: begin
               state     <= IDLE;
               o_bps_en  <= 1'b0;
               o_busy    <= 1'b0;
               o_uart_tx <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_m_uart_tx_arb.sv
// ---------------------------------------------------------------------------
// tb_m_uart_tx_arb
//
// Drives two instances of m_uart_tx_arb: the default 8N1 build and a 7-bit,
// two-stop-bit build. Each instance gets its own model baud generator that
// pulses once every 16 enabled cycles. Frames are decoded straight off the
// serial line and compared with the byte the winning requester offered.
// ---------------------------------------------------------------------------
module tb_m_uart_tx_arb;

   localparam int BIT_CYCLES = 16;

   typedef struct {
      logic       req0;
      logic       req1;
      logic [7:0] data0;
      logic [7:0] data1;
      logic       expGrant;
   } vector_t;

   logic clk = 1'b0;
   logic rstN;

   logic       req0, req1;
   logic [7:0] data0, data1;
   logic       ack0, ack1, bpsEn, bpsDone, tx, busy, grantId, done;
   logic       strayDone;
   logic [3:0] bpsCnt;
   logic       genDone;

   logic       bReq0, bReq1;
   logic [6:0] bData0, bData1;
   logic       bAck0, bAck1, bBpsEn, bBpsDone, bTx, bBusy, bGrant, bDone;
   logic [3:0] bBpsCnt;
   logic       bGenDone;

   int checkCount = 0;
   int passCount  = 0;

   vector_t vecs [8];
   logic    modelLast;

   // Free-running system clock.
   always #5 clk = ~clk;

   m_uart_tx_arb dut (
      .i_clk      (clk),
      .i_rst_n    (rstN),
      .i_req0     (req0),
      .i_data0    (data0),
      .o_ack0     (ack0),
      .i_req1     (req1),
      .i_data1    (data1),
      .o_ack1     (ack1),
      .o_bps_en   (bpsEn),
      .i_bps_done (bpsDone),
      .o_uart_tx  (tx),
      .o_busy     (busy),
      .o_grant_id (grantId),
      .o_done     (done)
   );

   m_uart_tx_arb #(.DATA_BITS(7), .STOP_BITS(2)) dut2 (
      .i_clk      (clk),
      .i_rst_n    (rstN),
      .i_req0     (bReq0),
      .i_data0    (bData0),
      .o_ack0     (bAck0),
      .i_req1     (bReq1),
      .i_data1    (bData1),
      .o_ack1     (bAck1),
      .o_bps_en   (bBpsEn),
      .i_bps_done (bBpsDone),
      .o_uart_tx  (bTx),
      .o_busy     (bBusy),
      .o_grant_id (bGrant),
      .o_done     (bDone)
   );

   // Model baud generator for the main instance: counter held clear while
   // the enable is low, one pulse every 16 enabled cycles. Stray pulses can
   // be injected on top of it while the block is idle.
   always @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         bpsCnt  <= 4'd0;
         genDone <= 1'b0;
      end else if (!bpsEn) begin
         bpsCnt  <= 4'd0;
         genDone <= 1'b0;
      end else if (bpsCnt == 4'd15) begin
         bpsCnt  <= 4'd0;
         genDone <= 1'b1;
      end else begin
         bpsCnt  <= bpsCnt + 4'd1;
         genDone <= 1'b0;
      end
   end

   assign bpsDone = genDone | strayDone;

   // Same baud model for the 7-bit / two-stop-bit instance.
   always @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         bBpsCnt  <= 4'd0;
         bGenDone <= 1'b0;
      end else if (!bBpsEn) begin
         bBpsCnt  <= 4'd0;
         bGenDone <= 1'b0;
      end else if (bBpsCnt == 4'd15) begin
         bBpsCnt  <= 4'd0;
         bGenDone <= 1'b1;
      end else begin
         bBpsCnt  <= bBpsCnt + 4'd1;
         bGenDone <= 1'b0;
      end
   end

   assign bBpsDone = bGenDone;

   // Instance selectors so one frame decoder serves both builds.
   function automatic logic txOf(input int sel);
      return (sel == 1) ? bTx : tx;
   endfunction

   function automatic logic doneOf(input int sel);
      return (sel == 1) ? bDone : done;
   endfunction

   function automatic logic ackOf(input int sel);
      return (sel == 1) ? (bAck0 | bAck1) : (ack0 | ack1);
   endfunction

   function automatic logic busyOf(input int sel);
      return (sel == 1) ? bBusy : busy;
   endfunction

   function automatic logic grantOf(input int sel);
      return (sel == 1) ? bGrant : grantId;
   endfunction

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Drives the main instance's request inputs; called on a falling edge.
   task automatic applyStimulus(input logic r0, input logic r1, input logic [7:0] d0, input logic [7:0] d1);
      req0  = r0;
      req1  = r1;
      data0 = d0;
      data1 = d1;
   endtask

   // Resets both instances and leaves the bench on a falling edge.
   task automatic doReset();
      rstN      = 1'b0;
      strayDone = 1'b0;
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
      bReq0  = 1'b0;
      bReq1  = 1'b0;
      bData0 = 7'h00;
      bData1 = 7'h00;
      repeat (3) @(negedge clk);
      rstN = 1'b1;
   endtask

   // Decodes one frame from the serial line, starting on the falling edge
   // where the ack was seen. Checks the sync period, every bit level at both
   // its first and last cycle, the done pulse timing and that no ack fires
   // mid-frame. Leaves the bench on the falling edge where done is high.
   task automatic checkFrame(input int sel, input int dataBits, input int stopBits,
                             input logic [7:0] expData, input logic expGrant, input string tag);
      logic txS   [0:199];
      logic doneS [0:199];
      int   waitCnt;
      int   nCyc;
      int   earlyDone;
      int   strayAck;
      logic expBit;
      logic startSeen;
      waitCnt   = 0;
      earlyDone = 0;
      strayAck  = 0;
      @(negedge clk);
      while (txOf(sel) !== 1'b0 && waitCnt < 200) begin
         if (ackOf(sel)) strayAck++;
         @(negedge clk);
         waitCnt++;
      end
      startSeen = (txOf(sel) === 1'b0);
      checkOutput({tag, "_start_seen"}, startSeen, 1);
      if (!startSeen) return;
      checkOutput({tag, "_sync_len"}, waitCnt, BIT_CYCLES);
      checkOutput({tag, "_grant"}, grantOf(sel), expGrant);
      nCyc = BIT_CYCLES * (1 + dataBits + stopBits);
      for (int i = 0; i <= nCyc; i++) begin
         if (i > 0) @(negedge clk);
         txS[i]   = txOf(sel);
         doneS[i] = doneOf(sel);
         if (ackOf(sel)) strayAck++;
         if (i < nCyc && doneOf(sel)) earlyDone++;
      end
      for (int b = 0; b < 1 + dataBits + stopBits; b++) begin
         if (b == 0) expBit = 1'b0;
         else if (b <= dataBits) expBit = expData[b-1];
         else expBit = 1'b1;
         checkOutput($sformatf("%s_bit%0d", tag, b), {txS[b*BIT_CYCLES], txS[b*BIT_CYCLES+BIT_CYCLES-1]},
                     {expBit, expBit});
      end
      checkOutput({tag, "_done_end"}, doneS[nCyc], 1);
      checkOutput({tag, "_done_early"}, earlyDone, 0);
      checkOutput({tag, "_busy_end"}, busyOf(sel), 0);
      checkOutput({tag, "_tx_end"}, txS[nCyc], 1);
      checkOutput({tag, "_ack_in_frame"}, strayAck, 0);
   endtask

   // One arbitrated transaction on the main instance: request, ack check,
   // optional scrambling of the source data, then full frame decode.
   task automatic runTransaction(input logic r0, input logic r1, input logic [7:0] d0, input logic [7:0] d1,
                                 input logic expGrant, input string tag, input logic scramble);
      logic [7:0] expData;
      applyStimulus(r0, r1, d0, d1);
      @(negedge clk);
      checkOutput({tag, "_ack0"}, ack0, !expGrant);
      checkOutput({tag, "_ack1"}, ack1, expGrant);
      checkOutput({tag, "_busy"}, busy, 1);
      checkOutput({tag, "_bps_en"}, bpsEn, 1);
      req0 = 1'b0;
      req1 = 1'b0;
      expData = expGrant ? d1 : d0;
      if (scramble) begin
         data0 = 8'($urandom);
         data1 = 8'($urandom);
      end
      checkFrame(0, 8, 1, expData, expGrant, tag);
   endtask

   // Hard stop in case anything fails to terminate.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main test sequence.
   initial begin
      int         waitCnt;
      int         pattern;
      int         gap;
      logic       r0, r1, expG;
      logic [7:0] d0, d1;

      vecs[0] = '{1'b1, 1'b0, 8'hA5, 8'h00, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 8'hC3, 8'h3C, 1'b1};
      vecs[2] = '{1'b1, 1'b1, 8'h0F, 8'hF0, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 8'h00, 8'h81, 1'b1};
      vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h7E, 1'b1};
      vecs[5] = '{1'b1, 1'b1, 8'h00, 8'hFF, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 8'h55, 8'h00, 1'b0};
      vecs[7] = '{1'b1, 1'b1, 8'hAA, 8'h01, 1'b1};

      doReset();
      @(negedge clk);
      checkOutput("rst_tx", tx, 1);
      checkOutput("rst_bps_en", bpsEn, 0);
      checkOutput("rst_ack0", ack0, 0);
      checkOutput("rst_ack1", ack1, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_grant", grantId, 0);
      checkOutput("rst_b_tx", bTx, 1);

      $display("[TB] stray baud pulses while idle");
      for (int k = 0; k < 3; k++) begin
         strayDone = 1'b1;
         @(negedge clk);
         strayDone = 1'b0;
         @(negedge clk);
         checkOutput($sformatf("stray%0d_tx", k), tx, 1);
         checkOutput($sformatf("stray%0d_busy", k), busy, 0);
         checkOutput($sformatf("stray%0d_bps_en", k), bpsEn, 0);
      end

      $display("[TB] single send with data changed after ack");
      runTransaction(1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, "single", 1'b1);

      $display("[TB] contention from reset");
      doReset();
      applyStimulus(1'b1, 1'b1, 8'h5A, 8'h3C);
      @(negedge clk);
      checkOutput("cont_ack0", ack0, 1);
      checkOutput("cont_ack1", ack1, 0);
      req0 = 1'b0;
      checkFrame(0, 8, 1, 8'h5A, 1'b0, "cont_f0");
      @(negedge clk);
      checkOutput("cont_ack1_after_done", ack1, 1);
      checkOutput("cont_done_pulse", done, 0);
      req1 = 1'b0;
      checkFrame(0, 8, 1, 8'h3C, 1'b1, "cont_f1");

      $display("[TB] fairness with both requests held");
      doReset();
      applyStimulus(1'b1, 1'b1, 8'h11, 8'h22);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkOutput($sformatf("fair%0d_ack0", k), ack0, (k % 2 == 0));
         checkOutput($sformatf("fair%0d_ack1", k), ack1, (k % 2 == 1));
         checkFrame(0, 8, 1, (k % 2 == 1) ? 8'h22 : 8'h11, 1'((k % 2)), $sformatf("fair%0d", k));
      end
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);

      $display("[TB] reset during data bit 3");
      doReset();
      applyStimulus(1'b1, 1'b0, 8'h96, 8'h6B);
      @(negedge clk);
      checkOutput("mrst_ack0", ack0, 1);
      req0 = 1'b0;
      req1 = 1'b1;
      waitCnt = 0;
      while (tx !== 1'b0 && waitCnt < 200) begin
         @(negedge clk);
         waitCnt++;
      end
      checkOutput("mrst_start_seen", (tx === 1'b0), 1);
      repeat (BIT_CYCLES * 4 + 5) @(negedge clk);
      checkOutput("mrst_busy_before", busy, 1);
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("mrst_tx", tx, 1);
      checkOutput("mrst_bps_en", bpsEn, 0);
      checkOutput("mrst_busy", busy, 0);
      checkOutput("mrst_ack", ack0 | ack1, 0);
      checkOutput("mrst_done", done, 0);
      @(negedge clk);
      @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);
      checkOutput("mrst_ack1_after", ack1, 1);
      checkOutput("mrst_ack0_after", ack0, 0);
      req1 = 1'b0;
      checkFrame(0, 8, 1, 8'h6B, 1'b1, "mrst_frame");

      $display("[TB] table-driven transactions");
      doReset();
      foreach (vecs[i]) begin
         runTransaction(vecs[i].req0, vecs[i].req1, vecs[i].data0, vecs[i].data1,
                        vecs[i].expGrant, $sformatf("vec%0d", i), 1'b0);
      end

      $display("[TB] randomized transactions against reference arbiter");
      doReset();
      modelLast = 1'b1;
      for (int t = 0; t < 20; t++) begin
         gap = $urandom_range(1, 6);
         for (int g = 0; g < gap; g++) begin
            strayDone = ($urandom_range(0, 1) == 1) && !strayDone;
            @(negedge clk);
         end
         strayDone = 1'b0;
         @(negedge clk);
         checkOutput($sformatf("rnd%0d_idle_tx", t), tx, 1);
         checkOutput($sformatf("rnd%0d_idle_busy", t), busy, 0);
         pattern = $urandom_range(1, 3);
         r0 = pattern[0];
         r1 = pattern[1];
         d0 = 8'($urandom);
         d1 = 8'($urandom);
         expG = (r0 && r1) ? ~modelLast : r1;
         modelLast = expG;
         runTransaction(r0, r1, d0, d1, expG, $sformatf("rnd%0d", t), 1'b1);
      end

      $display("[TB] seven data bits, two stop bits");
      bReq0  = 1'b1;
      bData0 = 7'h55;
      @(negedge clk);
      checkOutput("d7s2_ack0", bAck0, 1);
      checkOutput("d7s2_bps_en", bBpsEn, 1);
      bReq0  = 1'b0;
      bData0 = 7'h2A;
      checkFrame(1, 7, 2, 8'h55, 1'b0, "d7s2");

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
